// File: rtl/inst_fetch_queue_way0.sv
// Instruction fetch queue feeding the way0 decoder.
//
// Buffers fetch responses (instruction word, address and a 2-bit packet ID)
// in a small circular FIFO. There is no bypass path: an entry written in one
// cycle becomes visible at the head in the following cycle.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst          - synchronous active-high reset
//   flush_i      - pipeline redirect, discards every queued entry
//   fetchValid_i - fetch response carries a valid instruction
//   fetchInst_i  - fetched instruction word
//   fetchAddr_i  - address of the fetched instruction
//   fetchReady_o - queue can accept a fetch response this cycle
//   valid_o      - head entry valid toward the way0 decoder
//   inst_o       - head instruction word
//   instAddr_o   - head instruction address
//   way0_pID_o   - packet ID tag of the head entry
//   ready_i      - decoder accepts the head this cycle
//   count_o      - current occupancy
module inst_fetch_queue_way0 #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       fetchValid_i,
  input  logic [31:0]                fetchInst_i,
  input  logic [ADDR_W-1:0]          fetchAddr_i,
  output logic                       fetchReady_o,
  output logic                       valid_o,
  output logic [31:0]                inst_o,
  output logic [ADDR_W-1:0]          instAddr_o,
  output logic [1:0]                 way0_pID_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [31:0]       inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [1:0]        pid_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       pid_ctr;

  logic push;
  logic pop;

  // Readiness depends only on occupancy, so a full queue never accepts a
  // fetch even when the decoder is popping in the same cycle.
  assign fetchReady_o = (count < FULL_COUNT);
  assign valid_o      = (count != '0);
  assign count_o      = count;

  assign push = fetchValid_i && fetchReady_o && !flush_i && !rst;
  assign pop  = valid_o && ready_i && !flush_i && !rst;

  assign inst_o     = inst_mem[rd_ptr];
  assign instAddr_o = addr_mem[rd_ptr];
  assign way0_pID_o = pid_mem[rd_ptr];

  // Entry storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= fetchInst_i;
      addr_mem[wr_ptr] <= fetchAddr_i;
      pid_mem[wr_ptr]  <= pid_ctr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Flush clears
  // the queue but keeps the packet ID counter running, so tags issued after
  // a redirect never alias the last tag issued before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pid_ctr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        pid_ctr <= pid_ctr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue_way0.sv
// Self-checking bench for inst_fetch_queue_way0.
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based reference model of the FIFO behaviour.
module tb_inst_fetch_queue_way0;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              flushIn;
  logic              fetchValid;
  logic [31:0]       fetchInst;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchReady;
  logic              validOut;
  logic [31:0]       instOut;
  logic [ADDR_W-1:0] instAddrOut;
  logic [1:0]        pidOut;
  logic              readyIn;
  logic [2:0]        countOut;

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        pid;
  } entry_t;

  entry_t modelQ[$];
  int     modelPid;
  int     checkCount;
  int     errorCount;
  logic [31:0] heldInst;
  logic [ADDR_W-1:0] heldAddr;
  logic [1:0] heldPid;

  inst_fetch_queue_way0 #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flushIn),
    .fetchValid_i (fetchValid),
    .fetchInst_i  (fetchInst),
    .fetchAddr_i  (fetchAddr),
    .fetchReady_o (fetchReady),
    .valid_o      (validOut),
    .inst_o       (instOut),
    .instAddr_o   (instAddrOut),
    .way0_pID_o   (pidOut),
    .ready_i      (readyIn),
    .count_o      (countOut)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Compares every visible output against the reference model; head
  // fields only matter while the model holds something.
  task automatic checkAll();
    checkOutput("count", 64'(countOut), 64'(modelQ.size()));
    checkOutput("valid", 64'(validOut), 64'(modelQ.size() != 0));
    checkOutput("fetchReady", 64'(fetchReady), 64'(modelQ.size() < DEPTH));
    if (modelQ.size() != 0) begin
      checkOutput("headInst", 64'(instOut), 64'(modelQ[0].inst));
      checkOutput("headAddr", 64'(instAddrOut), 64'(modelQ[0].addr));
      checkOutput("headPid", 64'(pidOut), 64'(modelQ[0].pid));
    end
  endtask

  // Drives one cycle of inputs, advances the reference model across the
  // rising edge and checks outputs at the following falling edge.
  task automatic applyStimulus(input logic r, input logic f, input logic fv,
                               input logic [31:0] inst,
                               input logic [ADDR_W-1:0] addr,
                               input logic rdy);
    bit doPush;
    bit doPop;
    rst        = r;
    flushIn    = f;
    fetchValid = fv;
    fetchInst  = inst;
    fetchAddr  = addr;
    readyIn    = rdy;
    @(posedge clk);
    if (r) begin
      modelQ.delete();
      modelPid = 0;
    end else if (f) begin
      modelQ.delete();
    end else begin
      doPush = fv && (modelQ.size() < DEPTH);
      doPop  = rdy && (modelQ.size() != 0);
      if (doPop) void'(modelQ.pop_front());
      if (doPush) begin
        modelQ.push_back('{inst: inst, addr: addr, pid: 2'(modelPid)});
        modelPid = (modelPid + 1) % 4;
      end
    end
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelPid   = 0;

    // Reset and single push with decoder stalled.
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("rstCount", 64'(countOut), 64'd0);
    checkOutput("rstReady", 64'(fetchReady), 64'd1);
    applyStimulus(0, 0, 1, 32'h00000013, 32'h80000000, 0);
    checkOutput("firstValid", 64'(validOut), 64'd1);
    checkOutput("firstInst", 64'(instOut), 64'h00000013);
    checkOutput("firstAddr", 64'(instAddrOut), 64'h80000000);
    checkOutput("firstPid", 64'(pidOut), 64'd0);
    checkOutput("firstCount", 64'(countOut), 64'd1);

    // Fill to full, offer a fifth fetch, then drain in order.
    for (int i = 1; i < 4; i++)
      applyStimulus(0, 0, 1, 32'h10000000 + 32'(i), 32'h80000000 + 32'(4 * i), 0);
    checkOutput("fullCount", 64'(countOut), 64'd4);
    checkOutput("fullReady", 64'(fetchReady), 64'd0);
    applyStimulus(0, 0, 1, 32'hDEADBEEF, 32'h90000000, 0);
    checkOutput("fifthIgnored", 64'(countOut), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drainPid", 64'(pidOut), 64'(i));
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
    end
    checkOutput("drainedValid", 64'(validOut), 64'd0);

    // Steady push+pop at occupancy two; pID and pointers wrap.
    applyStimulus(0, 0, 1, 32'h20000000, 32'h80001000, 0);
    applyStimulus(0, 0, 1, 32'h20000001, 32'h80001004, 0);
    for (int i = 2; i < 12; i++) begin
      applyStimulus(0, 0, 1, 32'h20000000 + 32'(i), 32'h80001000 + 32'(4 * i), 1);
      checkOutput("steadyCount", 64'(countOut), 64'd2);
    end

    // Flush with three entries while push and pop are also requested.
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1, 32'h30000000 + 32'(i), 32'h80002000 + 32'(4 * i), 0);
    applyStimulus(0, 1, 1, 32'h3000FFFF, 32'h8000FFFF, 1);
    checkOutput("flushCount", 64'(countOut), 64'd0);
    checkOutput("flushValid", 64'(validOut), 64'd0);
    applyStimulus(0, 0, 1, 32'h30000010, 32'h80002100, 0);
    checkOutput("postFlushPid", 64'(pidOut), 64'd3);

    // Reset wins over flush and push; pID restarts at zero.
    applyStimulus(0, 0, 1, 32'h40000000, 32'h80003000, 0);
    applyStimulus(1, 1, 1, 32'h40000001, 32'h80003004, 1);
    checkOutput("rstOverFlushCount", 64'(countOut), 64'd0);
    applyStimulus(0, 0, 1, 32'h40000002, 32'h80003008, 0);
    checkOutput("postRstPid", 64'(pidOut), 64'd0);

    // Stalled head stays stable while the queue keeps filling.
    heldInst = 32'h40000002;
    heldAddr = 32'h80003008;
    heldPid  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 32'h50000000 + 32'(i), 32'h80004000 + 32'(4 * i), 0);
      checkOutput("stallInst", 64'(instOut), 64'(heldInst));
      checkOutput("stallAddr", 64'(instAddrOut), 64'(heldAddr));
      checkOutput("stallPid", 64'(pidOut), 64'(heldPid));
      checkOutput("stallCount", 64'(countOut), 64'((i + 2 > 4) ? 4 : i + 2));
    end

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) < 7),
                    $urandom(), $urandom(),
                    ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
